// File: rtl/sram_rd_stream.sv
// Burst read client for the 16x8 two-port SRAM: issues reads, captures registered data, streams it out.
// Optional abort input enabled by defining SRAM_RD_STREAM_ABORT_EN.
module sram_rd_stream #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_len,
  output logic          mem_en_r,
  output logic [AW-1:0] mem_addr_r,
  input  logic [DW-1:0] mem_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
`ifdef SRAM_RD_STREAM_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      issue_addr, remaining, hold_addr;
  logic               pend, pend_last;
  logic [3:0][DW-1:0] buf_data;
  logic [3:0]         buf_last;
  logic [1:0]         wr_ptr, rd_ptr;
  logic [2:0]         occ;
  logic               issue, push, pop, abort_hit;
  logic [3:0]         credit_used;

`ifdef SRAM_RD_STREAM_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Credit counts the in-flight read but not a same-cycle pop.
  assign credit_used = {1'b0, occ} + {3'b000, pend};
  assign push        = pend;
  assign pop         = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) state_nxt = RUN;
      end
      RUN: begin
        if (credit_used < 4'd4) begin
          issue = 1'b1;
          if (remaining == '0) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_addr <= '0;
      remaining  <= '0;
      hold_addr  <= '0;
      pend       <= 1'b0;
      pend_last  <= 1'b0;
    end else begin
      pend      <= issue && !abort_hit;
      pend_last <= issue && (remaining == '0) && !abort_hit;
      if (state == IDLE && req_valid) begin
        issue_addr <= req_addr;
        remaining  <= req_len;
      end else if (issue) begin
        issue_addr <= issue_addr + 1'b1;
        remaining  <= remaining - 1'b1;
        hold_addr  <= issue_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data <= '0;
      buf_last <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
    end else if (abort_hit) begin
      wr_ptr <= rd_ptr;
      occ    <= '0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= mem_dout;
        buf_last[wr_ptr] <= pend_last;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Address output holds the last issued address while idle or stalled.
  assign mem_en_r   = issue;
  assign mem_addr_r = issue ? issue_addr : hold_addr;
  assign out_valid  = (occ != '0);
  assign out_data   = buf_data[rd_ptr];
  assign out_last   = out_valid && buf_last[rd_ptr];
  assign busy       = (state != IDLE);
  assign req_ready  = (state == IDLE);

endmodule

// File: tb/tb_sram_rd_stream.sv
// Scoreboard bench for sram_rd_stream with a behavioural registered SRAM read port.
// Abort scenario runs when SRAM_RD_STREAM_ABORT_EN is defined.
module tb_sram_rd_stream;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr, req_len;
  logic          mem_en_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_dout;
  logic          out_valid, out_ready, out_last, busy;
  logic [DW-1:0] out_data;
`ifdef SRAM_RD_STREAM_ABORT_EN
  logic          abort;
`endif

  logic [DW-1:0] mem [16];
  logic [8:0]    exp_q[$];
  logic [AW-1:0] addr_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int occ_m    = 0;
  int en_prev  = 0;
  int viol     = 0;
  int max_occ  = 0;
  int stalls   = 0;

  always #5 clk = ~clk;

  sram_rd_stream #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .mem_en_r   (mem_en_r),
    .mem_addr_r (mem_addr_r),
    .mem_dout   (mem_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
`ifdef SRAM_RD_STREAM_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy)
  );

  always @(posedge clk) if (mem_en_r) mem_dout <= mem[mem_addr_r];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and occupancy model, sampled mid-cycle.
  always @(negedge clk) begin
    int pop;
    logic [8:0]    e;
    logic [AW-1:0] a;
    if (!rst_n) begin
      exp_q.delete();
      addr_q.delete();
      occ_m   = 0;
      en_prev = 0;
    end else begin
      pop = int'(out_valid && out_ready);
      if (mem_en_r) begin
        check_eq("issue_expected", int'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) begin
          a = addr_q.pop_front();
          check_eq("mem_addr", int'(mem_addr_r), int'(a));
        end
        if (occ_m + en_prev >= 4) viol++;
      end else if (busy && addr_q.size() != 0) begin
        stalls++;
      end
      if (int'(out_valid) != int'(occ_m != 0)) viol++;
      if (pop != 0) begin
        check_eq("word_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("out_data", int'(out_data), int'(e[7:0]));
          check_eq("out_last", int'(out_last), int'(e[8]));
        end
      end
      occ_m   = occ_m + en_prev - pop;
      en_prev = int'(mem_en_r);
      if (occ_m > max_occ) max_occ = occ_m;
`ifdef SRAM_RD_STREAM_ABORT_EN
      if (abort && busy) begin
        exp_q.delete();
        addr_q.delete();
        occ_m   = 0;
        en_prev = 0;
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] l);
    int n = 0;
    logic [AW-1:0] ad;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("req_ready_wait", int'(req_ready), 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + AW'(i);
      addr_q.push_back(ad);
      exp_q.push_back({(i == int'(l)), mem[ad]});
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    tick();
    check_eq("idle_timeout", int'(busy), 0);
    check_eq("words_left", exp_q.size(), 0);
    check_eq("credit_model_viol", viol, 0);
    viol = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, int'(req_ready), 1);
    check_eq({tag, "_mem_en"}, int'(mem_en_r), 0);
    check_eq({tag, "_mem_addr"}, int'(mem_addr_r), 0);
    check_eq({tag, "_out_valid"}, int'(out_valid), 0);
    check_eq({tag, "_out_data"}, int'(out_data), 0);
    check_eq({tag, "_out_last"}, int'(out_last), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(i * 17);
    mem_dout  = '0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    out_ready = 1'b1;
`ifdef SRAM_RD_STREAM_ABORT_EN
    abort     = 1'b0;
`endif
    #3;
    check_reset_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic burst: latency and contiguous output.
    send(4'd3, 4'd4);
    check_eq("c0_mem_en", int'(mem_en_r), 1);
    check_eq("c0_req_ready", int'(req_ready), 0);
    check_eq("c0_busy", int'(busy), 1);
    tick();
    check_eq("c1_out_valid", int'(out_valid), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("burst_valid", int'(out_valid), 1);
    end
    tick();
    check_eq("after_out_valid", int'(out_valid), 0);
    check_eq("after_busy", int'(busy), 0);
    check_eq("after_req_ready", int'(req_ready), 1);
    wait_idle(40);

    // Address wrap; a request raised while busy must be ignored.
    send(4'd14, 4'd3);
    req_valid = 1'b1;
    req_addr  = 4'd0;
    req_len   = 4'd0;
    tick();
    req_valid = 1'b0;
    wait_idle(40);

    // Backpressure on cycles 3..8 of a 16-word burst.
    max_occ = 0;
    stalls  = 0;
    send(4'd0, 4'd15);
    for (int c = 1; c < 80 && busy; c++) begin
      tick();
      out_ready = !(c >= 3 && c <= 8);
    end
    out_ready = 1'b1;
    wait_idle(40);
    check_eq("bp_stalled", int'(stalls > 0), 1);
    check_eq("bp_max_occ", max_occ, 4);

    // Single word, then an immediate follow-up request.
    send(4'd7, 4'd0);
    check_eq("len0_c0_ready", int'(req_ready), 0);
    tick();
    check_eq("len0_c1_ready", int'(req_ready), 0);
    tick();
    check_eq("len0_c2_ready", int'(req_ready), 0);
    check_eq("len0_c2_valid", int'(out_valid), 1);
    check_eq("len0_c2_last", int'(out_last), 1);
    tick();
    check_eq("len0_c3_ready", int'(req_ready), 1);
    send(4'd2, 4'd1);
    wait_idle(40);

    // Asynchronous reset during the third word.
    send(4'd0, 4'd15);
    for (int i = 0; i < 4; i++) tick();
    check_eq("rst_third_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send(4'd5, 4'd1);
    wait_idle(40);

`ifdef SRAM_RD_STREAM_ABORT_EN
    // Abort with three words buffered and one read in flight.
    out_ready = 1'b0;
    send(4'd0, 4'd15);
    for (int i = 0; i < 4; i++) tick();
    check_eq("abort_occ_model", occ_m, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_out_valid", int'(out_valid), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_mem_en", int'(mem_en_r), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("post_abort_mem_en", int'(mem_en_r), 0);
      check_eq("post_abort_valid", int'(out_valid), 0);
    end
    out_ready = 1'b1;
    send(4'd9, 4'd2);
    wait_idle(40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
